// File: rtl/morse_key_sequencer.sv
// Straight-key front end: turns key press/gap timing into Dot/Dash/Space/EndSeq/Clear pulses.
// Optional key debounce is enabled by defining MORSE_KEY_DEBOUNCE_EN.
module morse_key_sequencer #(
    parameter int CNT_W      = 8,
    parameter int DOT_MAX    = 3,
    parameter int END_HOLD   = 12,
    parameter int LETTER_GAP = 3,
    parameter int WORD_GAP   = 7,
    parameter int MAX_SYMS   = 5
`ifdef MORSE_KEY_DEBOUNCE_EN
    ,
    parameter int DEB_TICKS  = 2
`endif
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Key,
    input  logic       Tick,
    output logic       Dot,
    output logic       Dash,
    output logic       Space,
    output logic       EndSeq,
    output logic       Clear,
    output logic [2:0] SymCount,
    output logic       Busy
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_PRESS,
        S_COMMIT,
        S_GAP,
        S_WGAP,
        S_FLUSH,
        S_END
    } state_t;

    localparam logic [CNT_W-1:0] DOT_C  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(END_HOLD);
    localparam logic [CNT_W-1:0] LGAP_C = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] WGAP_C = CNT_W'(WORD_GAP);
    localparam logic [2:0]       SYMS_C = 3'(MAX_SYMS);

    logic             key1_q, key2_q;
    logic             ks, ksp_q;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [2:0]       sym_q, sym_d, sym_inc;
    logic             dot_q, dot_d;
    logic             dash_q, dash_d;
    logic             space_q, space_d;
    logic             end_q, end_d;
    logic             clr_q, clr_d;
    logic             busy_q, busy_d;

`ifdef MORSE_KEY_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_TICKS + 1);

    logic          deb_q, deb_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    // The filtered level only moves after DEB_TICKS stable ticks of the new level
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = dcnt_q;
        if (key2_q == deb_q) begin
            dcnt_d = '0;
        end else if (Tick) begin
            if (dcnt_q == DW'(DEB_TICKS - 1)) begin
                deb_d  = key2_q;
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            deb_q  <= 1'b0;
            dcnt_q <= '0;
        end else begin
            deb_q  <= deb_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign ks = deb_q;
`else
    assign ks = key2_q;
`endif

    assign rise    = ks & ~ksp_q;
    assign fall    = ~ks & ksp_q;
    assign sym_inc = sym_q + 3'd1;

    // An edge restarts the measurement and swallows a coincident tick
    always_comb begin
        cnt_d = cnt_q;
        if (rise || fall) begin
            cnt_d = '0;
        end else if (Tick && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        dot_d   = 1'b0;
        dash_d  = 1'b0;
        space_d = 1'b0;
        end_d   = 1'b0;
        clr_d   = 1'b0;
        unique case (state_q)
            S_INIT: begin
                clr_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (ks) state_d = S_PRESS;
            end
            S_PRESS: begin
                if (fall) begin
                    if (cnt_q >= HOLD_C) begin
                        state_d = S_FLUSH;
                    end else begin
                        dot_d   = (cnt_q < DOT_C);
                        dash_d  = (cnt_q >= DOT_C);
                        sym_d   = sym_inc;
                        state_d = (sym_inc == SYMS_C) ? S_COMMIT : S_GAP;
                    end
                end
            end
            S_COMMIT: begin
                space_d = 1'b1;
                sym_d   = '0;
                // A press may already start while the full letter is flushed
                state_d = rise ? S_PRESS : S_WGAP;
            end
            S_GAP: begin
                if (rise) begin
                    state_d = S_PRESS;
                end else if (cnt_q == LGAP_C) begin
                    space_d = 1'b1;
                    sym_d   = '0;
                    state_d = S_WGAP;
                end
            end
            S_WGAP: begin
                if (rise) begin
                    state_d = S_PRESS;
                end else if (cnt_q == WGAP_C) begin
                    space_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                space_d = (sym_q != '0);
                sym_d   = '0;
                state_d = S_END;
            end
            S_END: begin
                end_d   = 1'b1;
                state_d = S_INIT;
            end
            default: state_d = S_INIT;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            key1_q  <= 1'b0;
            key2_q  <= 1'b0;
            ksp_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_INIT;
            sym_q   <= '0;
            dot_q   <= 1'b0;
            dash_q  <= 1'b0;
            space_q <= 1'b0;
            end_q   <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            key1_q  <= Key;
            key2_q  <= key1_q;
            ksp_q   <= ks;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            sym_q   <= sym_d;
            dot_q   <= dot_d;
            dash_q  <= dash_d;
            space_q <= space_d;
            end_q   <= end_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
        end
    end

    assign Dot      = dot_q;
    assign Dash     = dash_q;
    assign Space    = space_q;
    assign EndSeq   = end_q;
    assign Clear    = clr_q;
    assign SymCount = sym_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed and random key timing against an event-scheduling reference model.
module tb_morse_key_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Key = 1'b0;
    logic       Tick = 1'b0;
    logic       Dot, Dash, Space, EndSeq, Clear, Busy;
    logic [2:0] SymCount;

    int total = 0;
    int bad = 0;

    always #5 Clk = ~Clk;

    morse_key_sequencer dut (
        .Clk(Clk),
        .Reset(Reset),
        .Key(Key),
        .Tick(Tick),
        .Dot(Dot),
        .Dash(Dash),
        .Space(Space),
        .EndSeq(EndSeq),
        .Clear(Clear),
        .SymCount(SymCount),
        .Busy(Busy)
    );

    // Pulse codes: 1 dot, 2 dash, 3 space, 4 endseq, 5 clear
    int  cyc_n = 0;
    bit  mk1, mks, mprev;
    int  mcnt;
    bit  m_init, m_down, m_open, m_closed, m_idle;
    int  quiet_until;
    int  nsym;
    int  cur_sym;
    int  sched_p[int];
    int  sched_s[int];
    int  n_dot, n_dash, n_space, n_end, n_clear;

    function automatic int pvec(input int code);
        return (code == 0) ? 0 : (1 << (code - 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic model_edge();
        bit rise, fall;
        int c;
        if (Reset) begin
            mk1 = 0; mks = 0; mprev = 0; mcnt = 0;
            m_init = 1; m_down = 0; m_open = 0; m_closed = 0; m_idle = 0;
            nsym = 0; cur_sym = 0; quiet_until = -1;
            sched_p.delete();
            sched_s.delete();
        end else begin
            c = cyc_n;
            rise = mks && !mprev;
            fall = !mks && mprev;
            if (m_init) begin
                sched_p[c+1] = 5;
                m_init = 0;
                m_idle = 1;
            end else if (c <= quiet_until) begin
                // flush / end-of-message / re-init cycles ignore the key
            end else if (!m_down && (rise || (m_idle && mks))) begin
                m_down = 1; m_idle = 0; m_open = 0; m_closed = 0;
            end else if (m_down && fall) begin
                m_down = 0;
                if (mcnt >= 12) begin
                    if (nsym > 0) begin
                        sched_p[c+2] = 3;
                        sched_s[c+2] = 0;
                    end
                    sched_p[c+3] = 4;
                    sched_p[c+4] = 5;
                    quiet_until = c + 3;
                    m_idle = 1;
                    nsym = 0;
                end else begin
                    nsym++;
                    sched_p[c+1] = (mcnt < 3) ? 1 : 2;
                    sched_s[c+1] = nsym;
                    if (nsym == 5) begin
                        sched_p[c+2] = 3;
                        sched_s[c+2] = 0;
                        nsym = 0;
                        m_closed = 1;
                    end else begin
                        m_open = 1;
                    end
                end
            end else if (!m_down && m_open && mcnt == 3) begin
                sched_p[c+1] = 3;
                sched_s[c+1] = 0;
                nsym = 0;
                m_open = 0;
                m_closed = 1;
            end else if (!m_down && m_closed && mcnt == 7) begin
                sched_p[c+1] = 3;
                m_closed = 0;
                m_idle = 1;
            end
            // ticks elapsed since the last key edge, edge cycle not counted
            if (mks != mprev) mcnt = 0;
            else if (Tick && mcnt < 255) mcnt = mcnt + 1;
            mprev = mks;
            mks = mk1;
            mk1 = Key;
        end
        cyc_n++;
    endtask

    task automatic compare();
        int ep;
        ep = 0;
        if (!Reset) begin
            if (sched_p.exists(cyc_n)) ep = sched_p[cyc_n];
            if (sched_s.exists(cyc_n)) cur_sym = sched_s[cyc_n];
        end else begin
            chk("rst_busy", 32'(Busy), 0);
        end
        chk("pulses", 32'({Clear, EndSeq, Space, Dash, Dot}), pvec(ep));
        chk("symcount", 32'(SymCount), cur_sym);
        n_dot   += int'(Dot);
        n_dash  += int'(Dash);
        n_space += int'(Space);
        n_end   += int'(EndSeq);
        n_clear += int'(Clear);
    endtask

    task automatic cyc(input bit k, input bit t, input bit r = 1'b0);
        Key = k;
        Tick = t;
        Reset = r;
        @(posedge Clk);
        model_edge();
        #1;
        compare();
        @(negedge Clk);
    endtask

    task automatic press(input int n, input int g, input bit rt = 1'b0);
        for (int i = 0; i < n; i++)
            cyc(1'b1, rt ? ($urandom_range(0, 2) != 0) : 1'b1);
        for (int i = 0; i < g; i++)
            cyc(1'b0, rt ? ($urandom_range(0, 2) != 0) : 1'b1);
    endtask

    int s_dot, s_dash, s_space, s_end, s_clear;

    task automatic snap();
        s_dot = n_dot; s_dash = n_dash; s_space = n_space;
        s_end = n_end; s_clear = n_clear;
    endtask

    initial begin
        n_dot = 0; n_dash = 0; n_space = 0; n_end = 0; n_clear = 0;
        @(negedge Clk);

        // reset, then a single Clear
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        snap();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
        chk("t1_clear", n_clear - s_clear, 1);
        chk("t1_other", (n_dot + n_dash + n_space + n_end)
                        - (s_dot + s_dash + s_space + s_end), 0);
        chk("t1_busy", 32'(Busy), 0);

        // dot then dash, letter space and word space
        snap();
        press(2, 1);
        press(5, 12);
        chk("t2_dot", n_dot - s_dot, 1);
        chk("t2_dash", n_dash - s_dash, 1);
        chk("t2_space", n_space - s_space, 2);
        chk("t2_busy", 32'(Busy), 0);

        // five dots auto-commit, sixth starts a new letter
        snap();
        for (int i = 0; i < 5; i++) press(1, 1);
        press(1, 12);
        chk("t3_dot", n_dot - s_dot, 6);
        chk("t3_space", n_space - s_space, 3);

        // long hold after a symbol and from idle
        snap();
        press(1, 1);
        press(14, 8);
        press(14, 8);
        chk("t4_dot", n_dot - s_dot, 1);
        chk("t4_space", n_space - s_space, 1);
        chk("t4_end", n_end - s_end, 2);
        chk("t4_clear", n_clear - s_clear, 2);
        chk("t4_busy", 32'(Busy), 0);

        // reset in the middle of a press
        snap();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1);
        chk("t5_clear", n_clear - s_clear, 1);
        chk("t5_dot", n_dot - s_dot, 1);
        chk("t5_dash", n_dash - s_dash, 0);
        chk("t5_end", n_end - s_end, 0);

        // counter saturation on a very long hold
        snap();
        press(300, 10);
        chk("sat_end", n_end - s_end, 1);
        chk("sat_space", n_space - s_space, 0);

        // random timing, every tick then sparse ticks
        for (int i = 0; i < 80; i++) begin
            int p;
            int g;
            p = $urandom_range(1, 16);
            g = (p >= 13) ? $urandom_range(6, 14) : $urandom_range(1, 12);
            press(p, g);
        end
        for (int i = 0; i < 80; i++) begin
            int p;
            int g;
            p = $urandom_range(1, 16);
            g = (p >= 13) ? $urandom_range(6, 14) : $urandom_range(1, 12);
            press(p, g, 1'b1);
        end
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);
        chk("end_busy", 32'(Busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
